// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register with valid/ready handshaking, a two-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
// ID_Ready comes from registered state only, so there is no combinational
// path from EX_Ready back to ID.
module id_ex_elastic_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned SHAMT_W = 5,
  parameter int unsigned CTRL_W  = 9,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               ID_Valid,
  output logic               ID_Ready,
  input  logic               ID_Flush,
  input  logic [CTRL_W-1:0]  ID_Ctrl,
  input  logic [SHAMT_W-1:0] ID_Shamt,
  input  logic [DATA_W-1:0]  ID_RegA,
  input  logic [DATA_W-1:0]  ID_RegB,
  input  logic [RADDR_W-1:0] ID_Regrt,
  input  logic [RADDR_W-1:0] ID_Regrd,
  input  logic [DATA_W-1:0]  ID_ImmExt,
  output logic               EX_Valid,
  input  logic               EX_Ready,
  output logic [CTRL_W-1:0]  EX_Ctrl,
  output logic [DATA_W-1:0]  EX_Shamt,
  output logic [DATA_W-1:0]  EX_RegA,
  output logic [DATA_W-1:0]  EX_RegB,
  output logic [RADDR_W-1:0] EX_Regrt,
  output logic [RADDR_W-1:0] EX_Regrd,
  output logic [DATA_W-1:0]  EX_ImmExt,
  output logic [CNT_W-1:0]   StallCnt
);

  localparam int unsigned BeatW = CTRL_W + SHAMT_W + 3 * DATA_W + 2 * RADDR_W;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StTwo   = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [1:0]       stateQ, stateD;
  logic             readyQ;
  logic [BeatW-1:0] headQ, headD;
  logic [BeatW-1:0] skidQ, skidD;
  logic [BeatW-1:0] inBeat;
  logic [CNT_W-1:0] cntQ;
  logic             accept, retire;

  logic [CTRL_W-1:0]  hCtrl;
  logic [SHAMT_W-1:0] hShamt;
  logic [DATA_W-1:0]  hRegA, hRegB, hImm;
  logic [RADDR_W-1:0] hRt, hRd;

  assign inBeat = {ID_Ctrl, ID_Shamt, ID_RegA, ID_RegB, ID_Regrt, ID_Regrd, ID_ImmExt};
  assign {hCtrl, hShamt, hRegA, hRegB, hRt, hRd, hImm} = headQ;

  assign EX_Valid = (stateQ != StEmpty);
  assign ID_Ready = readyQ;
  assign accept   = ID_Valid && readyQ;
  assign retire   = EX_Valid && EX_Ready;

  // Bubbles carry zero control so they can never write RF or memory.
  assign EX_Ctrl   = EX_Valid ? hCtrl : '0;
  assign EX_Shamt  = {{(DATA_W - SHAMT_W){1'b0}}, hShamt};
  assign EX_RegA   = hRegA;
  assign EX_RegB   = hRegB;
  assign EX_Regrt  = hRt;
  assign EX_Regrd  = hRd;
  assign EX_ImmExt = hImm;
  assign StallCnt  = cntQ;

  // Next-state: occupancy transitions and head/skid loading; flush wins.
  always_comb begin
    stateD = stateQ;
    headD  = headQ;
    skidD  = skidQ;
    case (stateQ)
      StEmpty: begin
        if (accept) begin
          stateD = StOne;
          headD  = inBeat;
        end
      end
      StOne: begin
        if (accept && retire) begin
          headD = inBeat;
        end else if (accept) begin
          stateD = StTwo;
          skidD  = inBeat;
        end else if (retire) begin
          stateD = StEmpty;
        end
      end
      StTwo: begin
        if (retire) begin
          stateD = StOne;
          headD  = skidQ;
        end
      end
      default: stateD = StEmpty;
    endcase
    if (ID_Flush) begin
      stateD = StEmpty;
    end
  end

  // State, payload and registered ready.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateQ <= StEmpty;
      readyQ <= 1'b0;
      headQ  <= '0;
      skidQ  <= '0;
    end else begin
      stateQ <= stateD;
      readyQ <= (stateD != StTwo);
      headQ  <= headD;
      skidQ  <= skidD;
    end
  end

  // Saturating count of cycles where EX holds off a valid head.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cntQ <= '0;
    end else if (EX_Valid && !EX_Ready && (cntQ != CntMax)) begin
      cntQ <= cntQ + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Self-checking bench for id_ex_elastic_reg: a queue scoreboard follows
// every accepted beat, a vector table drives the back-pressure and flush
// sequences, and hand-written sequences cover shamt/ctrl, saturation and
// asynchronous reset.
module tb_id_ex_elastic_reg;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
  } beat_t;

  typedef struct {
    bit idV;
    bit exR;
    bit fl;
    bit expV;
    bit expRdy;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ID_Valid, ID_Flush, EX_Ready;
  logic        ID_Ready, EX_Valid;
  logic [8:0]  ID_Ctrl, EX_Ctrl;
  logic [4:0]  ID_Shamt, ID_Regrt, ID_Regrd, EX_Regrt, EX_Regrd;
  logic [31:0] ID_RegA, ID_RegB, ID_ImmExt;
  logic [31:0] EX_Shamt, EX_RegA, EX_RegB, EX_ImmExt;
  logic [3:0]  StallCnt;

  int    nVec = 0;
  int    nErr = 0;
  beat_t sbQ[$];
  beat_t pend;
  bit    mReady;
  int    mCnt;
  vec_t  tbl[15];

  always #5 Clk = ~Clk;

  id_ex_elastic_reg #(
    .DATA_W (32),
    .RADDR_W(5),
    .SHAMT_W(5),
    .CTRL_W (9),
    .CNT_W  (4)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .ID_Valid (ID_Valid),
    .ID_Ready (ID_Ready),
    .ID_Flush (ID_Flush),
    .ID_Ctrl  (ID_Ctrl),
    .ID_Shamt (ID_Shamt),
    .ID_RegA  (ID_RegA),
    .ID_RegB  (ID_RegB),
    .ID_Regrt (ID_Regrt),
    .ID_Regrd (ID_Regrd),
    .ID_ImmExt(ID_ImmExt),
    .EX_Valid (EX_Valid),
    .EX_Ready (EX_Ready),
    .EX_Ctrl  (EX_Ctrl),
    .EX_Shamt (EX_Shamt),
    .EX_RegA  (EX_RegA),
    .EX_RegB  (EX_RegB),
    .EX_Regrt (EX_Regrt),
    .EX_Regrd (EX_Regrd),
    .EX_ImmExt(EX_ImmExt),
    .StallCnt (StallCnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t newBeat();
    beat_t bt;
    bt.ctrl  = 9'($urandom);
    bt.shamt = 5'($urandom);
    bt.a     = $urandom;
    bt.b     = $urandom;
    bt.rt    = 5'($urandom);
    bt.rd    = 5'($urandom);
    bt.imm   = $urandom;
    return bt;
  endfunction

  // Checks outputs against the model, then advances model and DUT one edge.
  task automatic cycle(input string tag);
    bit acc;
    bit ret;
    ID_Ctrl   = pend.ctrl;
    ID_Shamt  = pend.shamt;
    ID_RegA   = pend.a;
    ID_RegB   = pend.b;
    ID_Regrt  = pend.rt;
    ID_Regrd  = pend.rd;
    ID_ImmExt = pend.imm;
    #1;
    chk({tag, ".valid"}, 64'(EX_Valid), 64'(sbQ.size() > 0));
    chk({tag, ".ready"}, 64'(ID_Ready), 64'(mReady));
    chk({tag, ".stall"}, 64'(StallCnt), 64'(mCnt));
    if (sbQ.size() > 0) begin
      chk({tag, ".ctrl"}, 64'(EX_Ctrl), 64'(sbQ[0].ctrl));
      chk({tag, ".shamt"}, 64'(EX_Shamt), {59'd0, sbQ[0].shamt});
      chk({tag, ".rega"}, 64'(EX_RegA), 64'(sbQ[0].a));
      chk({tag, ".regb"}, 64'(EX_RegB), 64'(sbQ[0].b));
      chk({tag, ".rt"}, 64'(EX_Regrt), 64'(sbQ[0].rt));
      chk({tag, ".rd"}, 64'(EX_Regrd), 64'(sbQ[0].rd));
      chk({tag, ".imm"}, 64'(EX_ImmExt), 64'(sbQ[0].imm));
    end else begin
      chk({tag, ".ctrl0"}, 64'(EX_Ctrl), 64'd0);
    end
    acc = ID_Valid && mReady;
    ret = (sbQ.size() > 0) && EX_Ready;
    if ((sbQ.size() > 0) && !EX_Ready && (mCnt != 15)) mCnt++;
    if (ret) void'(sbQ.pop_front());
    if (ID_Flush) sbQ.delete();
    else if (acc) sbQ.push_back(pend);
    if (acc || (ID_Flush && ID_Valid)) pend = newBeat();
    @(posedge Clk);
    #1;
    mReady = (sbQ.size() < 2);
  endtask

  initial begin
    Rst      = 1'b1;
    ID_Valid = 1'b0;
    ID_Flush = 1'b0;
    EX_Ready = 1'b0;
    pend     = newBeat();
    mReady   = 1'b0;
    mCnt     = 0;

    // Reset state.
    repeat (2) @(posedge Clk);
    #1;
    chk("rst.valid", 64'(EX_Valid), 64'd0);
    chk("rst.ctrl", 64'(EX_Ctrl), 64'd0);
    chk("rst.rega", 64'(EX_RegA), 64'd0);
    chk("rst.shamt", 64'(EX_Shamt), 64'd0);
    chk("rst.imm", 64'(EX_ImmExt), 64'd0);
    chk("rst.stall", 64'(StallCnt), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    mReady = 1'b1;
    chk("rst.ready_after", 64'(ID_Ready), 64'd1);

    // Streaming at full throughput.
    EX_Ready = 1'b1;
    ID_Valid = 1'b1;
    for (int i = 0; i < 8; i++) cycle("stream");
    ID_Valid = 1'b0;
    for (int i = 0; i < 2; i++) cycle("stream_drain");
    chk("stream.stall_zero", 64'(StallCnt), 64'd0);

    // Shamt zero-extension and full control word.
    pend.shamt = 5'h1F;
    pend.ctrl  = 9'h1FF;
    ID_Valid   = 1'b1;
    EX_Ready   = 1'b0;
    cycle("shamt");
    ID_Valid = 1'b0;
    #1;
    chk("shamt.ext", 64'(EX_Shamt), 64'h1F);
    chk("shamt.ctrl", 64'(EX_Ctrl), 64'h1FF);
    EX_Ready = 1'b1;
    for (int i = 0; i < 2; i++) cycle("shamt_drain");

    // Back-pressure into skid, then flush from TWO and flush with retire.
    tbl[0]  = '{1, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 1, 0};
    tbl[3]  = '{1, 1, 0, 1, 0};
    tbl[4]  = '{1, 1, 0, 1, 1};
    tbl[5]  = '{0, 1, 0, 1, 1};
    tbl[6]  = '{0, 1, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 0, 1, 1};
    tbl[9]  = '{1, 0, 1, 1, 0};
    tbl[10] = '{0, 1, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 1};
    tbl[13] = '{1, 1, 1, 1, 1};
    tbl[14] = '{0, 1, 0, 0, 1};
    for (int i = 0; i < 15; i++) begin
      ID_Valid = tbl[i].idV;
      EX_Ready = tbl[i].exR;
      ID_Flush = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d.valid", i), 64'(EX_Valid), 64'(tbl[i].expV));
      chk($sformatf("tbl%0d.ready", i), 64'(ID_Ready), 64'(tbl[i].expRdy));
      cycle($sformatf("tbl%0d", i));
    end
    ID_Flush = 1'b0;

    // Stall counter saturation.
    ID_Valid = 1'b1;
    EX_Ready = 1'b0;
    cycle("sat_load");
    ID_Valid = 1'b0;
    for (int i = 0; i < 19; i++) cycle("sat");
    chk("sat.value", 64'(StallCnt), 64'hF);
    EX_Ready = 1'b1;
    cycle("sat_drain");
    chk("sat.hold", 64'(StallCnt), 64'hF);

    // Asynchronous reset while two beats are held.
    EX_Ready = 1'b0;
    ID_Valid = 1'b1;
    for (int i = 0; i < 2; i++) cycle("arst_fill");
    ID_Valid = 1'b0;
    chk("arst.pre_valid", 64'(EX_Valid), 64'd1);
    chk("arst.pre_ready", 64'(ID_Ready), 64'd0);
    #2;
    Rst = 1'b1;
    #1;
    chk("arst.valid", 64'(EX_Valid), 64'd0);
    chk("arst.ctrl", 64'(EX_Ctrl), 64'd0);
    chk("arst.rega", 64'(EX_RegA), 64'd0);
    chk("arst.imm", 64'(EX_ImmExt), 64'd0);
    chk("arst.stall", 64'(StallCnt), 64'd0);
    sbQ.delete();
    mCnt   = 0;
    mReady = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    mReady   = 1'b1;
    EX_Ready = 1'b1;
    ID_Valid = 1'b1;
    cycle("post_rst");
    ID_Valid = 1'b0;
    for (int i = 0; i < 2; i++) cycle("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
